// File: rtl/cluster_clock_gate_ctrl.sv
// Per-domain auto clock-gating controller: counts idle cycles, quiesces the
// domain through a req/ack handshake, and re-enables with a settle delay on wake.
module cluster_clock_gate_ctrl #(
    parameter int unsigned NUM_DOMAINS = 4,
    parameter int unsigned IDLE_CYCLES = 16,
    parameter int unsigned WAKE_CYCLES = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   test_en_i,
    input  logic                   ctrl_en_i,
    input  logic [NUM_DOMAINS-1:0] busy_i,
    input  logic [NUM_DOMAINS-1:0] wake_i,
    input  logic [NUM_DOMAINS-1:0] gate_ack_i,
    output logic [NUM_DOMAINS-1:0] gate_req_o,
    output logic [NUM_DOMAINS-1:0] clk_en_o,
    output logic [NUM_DOMAINS-1:0] ready_o
);

    localparam int unsigned MAX_CYC = (IDLE_CYCLES > WAKE_CYCLES) ? IDLE_CYCLES : WAKE_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'((WAKE_CYCLES > 0) ? WAKE_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        ST_ACTIVE,
        ST_DRAIN,
        ST_OFF,
        ST_WAKE
    } state_t;

    for (genvar d = 0; d < NUM_DOMAINS; d++) begin : g_dom
        state_t           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             req_q, en_q, rdy_q;
        logic             req_d, en_d, rdy_d;
        logic             idle;
        logic             wake_any;

        assign idle     = ctrl_en_i & ~test_en_i & ~busy_i[d] & ~wake_i[d];
        assign wake_any = wake_i[d] | test_en_i | ~ctrl_en_i;

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                state_q <= ST_ACTIVE;
                cnt_q   <= '0;
                req_q   <= 1'b0;
                en_q    <= 1'b1;
                rdy_q   <= 1'b1;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                req_q   <= req_d;
                en_q    <= en_d;
                rdy_q   <= rdy_d;
            end
        end

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            case (state_q)
                ST_ACTIVE: begin
                    if (!idle) begin
                        cnt_d = '0;
                    end else if (cnt_q == IDLE_LAST) begin
                        state_d = ST_DRAIN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                // Abort has priority over a coincident acknowledge.
                ST_DRAIN: begin
                    if (!idle) begin
                        state_d = ST_ACTIVE;
                        cnt_d   = '0;
                    end else if (gate_ack_i[d]) begin
                        state_d = ST_OFF;
                    end
                end
                ST_OFF: begin
                    if (wake_any) begin
                        cnt_d = '0;
                        if (WAKE_CYCLES == 0) state_d = ST_ACTIVE;
                        else                  state_d = ST_WAKE;
                    end
                end
                ST_WAKE: begin
                    if (cnt_q == WAKE_LAST) begin
                        state_d = ST_ACTIVE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_ACTIVE;
                    cnt_d   = '0;
                end
            endcase
        end

        // Outputs decoded from the next state and registered alongside it, so
        // they change on the same edge as the state without a comb output path.
        always_comb begin
            req_d = 1'b0;
            en_d  = 1'b1;
            rdy_d = 1'b1;
            case (state_d)
                ST_DRAIN: req_d = 1'b1;
                ST_OFF: begin
                    en_d  = 1'b0;
                    rdy_d = 1'b0;
                end
                ST_WAKE:  rdy_d = 1'b0;
                default:  ;
            endcase
        end

        assign gate_req_o[d] = req_q;
        assign clk_en_o[d]   = en_q;
        assign ready_o[d]    = rdy_q;
    end

endmodule

// File: tb/tb_cluster_clock_gate_ctrl.sv
// Scenario bench for cluster_clock_gate_ctrl: domain 0 is exercised, domains
// 1..3 are held busy and must stay clocked and ungated throughout.
module tb_cluster_clock_gate_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       test_en_i;
    logic       ctrl_en_i;
    logic [3:0] busy_i;
    logic [3:0] wake_i;
    logic [3:0] gate_ack_i;
    logic [3:0] gate_req_o;
    logic [3:0] clk_en_o;
    logic [3:0] ready_o;

    cluster_clock_gate_ctrl #(
        .NUM_DOMAINS(4),
        .IDLE_CYCLES(16),
        .WAKE_CYCLES(2)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .test_en_i  (test_en_i),
        .ctrl_en_i  (ctrl_en_i),
        .busy_i     (busy_i),
        .wake_i     (wake_i),
        .gate_ack_i (gate_ack_i),
        .gate_req_o (gate_req_o),
        .clk_en_o   (clk_en_o),
        .ready_o    (ready_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic       rst, ten, cen, b0, w0, a0;
        logic [2:0] ack_hi;
        logic       r0, e0, y0;
    } step_t;

    typedef struct {
        int         n;
        logic [3:0] req, en, rdy;
    } exp_t;

    step_t      stim[$];
    exp_t       exp_q[$];
    logic [2:0] ack_hi = 3'b000;
    int         checks = 0;
    int         errors = 0;
    int         n = 0;
    step_t      s;
    exp_t       e;

    // Queue one cycle: domain-0 inputs, then expected domain-0 outputs after the edge.
    function automatic void add(input logic rst, ten, cen, b0, w0, a0, r0, e0, y0);
        step_t t;
        t.rst = rst; t.ten = ten; t.cen = cen; t.b0 = b0; t.w0 = w0; t.a0 = a0;
        t.ack_hi = ack_hi; t.r0 = r0; t.e0 = e0; t.y0 = y0;
        stim.push_back(t);
    endfunction

    task automatic test_reset();
        add(1, 0, 1, 1, 0, 0, 0, 1, 1);
        add(1, 0, 1, 1, 0, 0, 0, 1, 1);
        while (stim.size() > 0) begin
            s = stim.pop_front();
            rst_i = s.rst; test_en_i = s.ten; ctrl_en_i = s.cen;
            busy_i = {3'b111, s.b0}; wake_i = {3'b000, s.w0}; gate_ack_i = {s.ack_hi, s.a0};
            exp_q.push_back('{n, {3'b000, s.r0}, {3'b111, s.e0}, {3'b111, s.y0}});
            @(posedge clk_i); #1; n++;
            e = exp_q.pop_front();
            checks++;
            if ({gate_req_o, clk_en_o, ready_o} !== {e.req, e.en, e.rdy}) begin
                errors++;
                $display("FAIL reset step %0d: req=%h en=%h rdy=%h, expected req=%h en=%h rdy=%h",
                         e.n, gate_req_o, clk_en_o, ready_o, e.req, e.en, e.rdy);
            end
        end
    endtask

    task automatic test_idle_gate();
        for (int i = 1; i <= 16; i++) add(0, 0, 1, 0, 0, 0, (i == 16), 1, 1);
        add(0, 0, 1, 0, 0, 0, 1, 1, 1);
        add(0, 0, 1, 0, 0, 0, 1, 1, 1);
        add(0, 0, 1, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) add(0, 0, 1, 1, 0, (i == 1), 0, 0, 0);
        while (stim.size() > 0) begin
            s = stim.pop_front();
            rst_i = s.rst; test_en_i = s.ten; ctrl_en_i = s.cen;
            busy_i = {3'b111, s.b0}; wake_i = {3'b000, s.w0}; gate_ack_i = {s.ack_hi, s.a0};
            exp_q.push_back('{n, {3'b000, s.r0}, {3'b111, s.e0}, {3'b111, s.y0}});
            @(posedge clk_i); #1; n++;
            e = exp_q.pop_front();
            checks++;
            if ({gate_req_o, clk_en_o, ready_o} !== {e.req, e.en, e.rdy}) begin
                errors++;
                $display("FAIL idle_gate step %0d: req=%h en=%h rdy=%h, expected req=%h en=%h rdy=%h",
                         e.n, gate_req_o, clk_en_o, ready_o, e.req, e.en, e.rdy);
            end
        end
    endtask

    task automatic test_wake();
        add(0, 0, 1, 1, 1, 0, 0, 1, 0);
        add(0, 0, 1, 1, 0, 0, 0, 1, 0);
        add(0, 0, 1, 1, 0, 0, 0, 1, 1);
        add(0, 0, 1, 1, 0, 0, 0, 1, 1);
        while (stim.size() > 0) begin
            s = stim.pop_front();
            rst_i = s.rst; test_en_i = s.ten; ctrl_en_i = s.cen;
            busy_i = {3'b111, s.b0}; wake_i = {3'b000, s.w0}; gate_ack_i = {s.ack_hi, s.a0};
            exp_q.push_back('{n, {3'b000, s.r0}, {3'b111, s.e0}, {3'b111, s.y0}});
            @(posedge clk_i); #1; n++;
            e = exp_q.pop_front();
            checks++;
            if ({gate_req_o, clk_en_o, ready_o} !== {e.req, e.en, e.rdy}) begin
                errors++;
                $display("FAIL wake step %0d: req=%h en=%h rdy=%h, expected req=%h en=%h rdy=%h",
                         e.n, gate_req_o, clk_en_o, ready_o, e.req, e.en, e.rdy);
            end
        end
    endtask

    task automatic test_busy_pulse();
        for (int i = 0; i < 15; i++) add(0, 0, 1, 0, 0, 0, 0, 1, 1);
        add(0, 0, 1, 1, 0, 0, 0, 1, 1);
        for (int i = 1; i <= 16; i++) add(0, 0, 1, 0, 0, 0, (i == 16), 1, 1);
        while (stim.size() > 0) begin
            s = stim.pop_front();
            rst_i = s.rst; test_en_i = s.ten; ctrl_en_i = s.cen;
            busy_i = {3'b111, s.b0}; wake_i = {3'b000, s.w0}; gate_ack_i = {s.ack_hi, s.a0};
            exp_q.push_back('{n, {3'b000, s.r0}, {3'b111, s.e0}, {3'b111, s.y0}});
            @(posedge clk_i); #1; n++;
            e = exp_q.pop_front();
            checks++;
            if ({gate_req_o, clk_en_o, ready_o} !== {e.req, e.en, e.rdy}) begin
                errors++;
                $display("FAIL busy_pulse step %0d: req=%h en=%h rdy=%h, expected req=%h en=%h rdy=%h",
                         e.n, gate_req_o, clk_en_o, ready_o, e.req, e.en, e.rdy);
            end
        end
    endtask

    task automatic test_abort();
        ack_hi = 3'b111;
        add(0, 0, 1, 1, 0, 1, 0, 1, 1);
        add(0, 0, 1, 1, 0, 0, 0, 1, 1);
        for (int i = 1; i <= 16; i++) add(0, 0, 1, 0, 0, 1, (i == 16), 1, 1);
        add(0, 0, 1, 0, 0, 1, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0, 0, 0, 0);
        ack_hi = 3'b000;
        while (stim.size() > 0) begin
            s = stim.pop_front();
            rst_i = s.rst; test_en_i = s.ten; ctrl_en_i = s.cen;
            busy_i = {3'b111, s.b0}; wake_i = {3'b000, s.w0}; gate_ack_i = {s.ack_hi, s.a0};
            exp_q.push_back('{n, {3'b000, s.r0}, {3'b111, s.e0}, {3'b111, s.y0}});
            @(posedge clk_i); #1; n++;
            e = exp_q.pop_front();
            checks++;
            if ({gate_req_o, clk_en_o, ready_o} !== {e.req, e.en, e.rdy}) begin
                errors++;
                $display("FAIL abort step %0d: req=%h en=%h rdy=%h, expected req=%h en=%h rdy=%h",
                         e.n, gate_req_o, clk_en_o, ready_o, e.req, e.en, e.rdy);
            end
        end
    endtask

    task automatic test_test_en();
        add(0, 1, 1, 0, 0, 0, 0, 1, 0);
        add(0, 1, 1, 0, 0, 0, 0, 1, 0);
        add(0, 1, 1, 0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 20; i++) add(0, 1, 1, 0, 0, 0, 0, 1, 1);
        for (int i = 1; i <= 16; i++) add(0, 0, 1, 0, 0, 0, (i == 16), 1, 1);
        add(0, 1, 1, 0, 0, 1, 0, 1, 1);
        add(0, 0, 1, 1, 0, 0, 0, 1, 1);
        while (stim.size() > 0) begin
            s = stim.pop_front();
            rst_i = s.rst; test_en_i = s.ten; ctrl_en_i = s.cen;
            busy_i = {3'b111, s.b0}; wake_i = {3'b000, s.w0}; gate_ack_i = {s.ack_hi, s.a0};
            exp_q.push_back('{n, {3'b000, s.r0}, {3'b111, s.e0}, {3'b111, s.y0}});
            @(posedge clk_i); #1; n++;
            e = exp_q.pop_front();
            checks++;
            if ({gate_req_o, clk_en_o, ready_o} !== {e.req, e.en, e.rdy}) begin
                errors++;
                $display("FAIL test_en step %0d: req=%h en=%h rdy=%h, expected req=%h en=%h rdy=%h",
                         e.n, gate_req_o, clk_en_o, ready_o, e.req, e.en, e.rdy);
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 1; i <= 16; i++) add(0, 0, 1, 0, 0, 0, (i == 16), 1, 1);
        add(1, 0, 1, 0, 0, 0, 0, 1, 1);
        for (int i = 1; i <= 16; i++) add(0, 0, 1, 0, 0, 0, (i == 16), 1, 1);
        add(0, 0, 1, 0, 0, 1, 0, 0, 0);
        add(1, 0, 1, 0, 0, 0, 0, 1, 1);
        for (int i = 1; i <= 16; i++) add(0, 0, 1, 0, 0, 0, (i == 16), 1, 1);
        add(0, 0, 1, 0, 0, 1, 0, 0, 0);
        add(0, 0, 1, 1, 1, 0, 0, 1, 0);
        add(1, 0, 1, 1, 0, 0, 0, 1, 1);
        add(0, 0, 1, 1, 0, 0, 0, 1, 1);
        while (stim.size() > 0) begin
            s = stim.pop_front();
            rst_i = s.rst; test_en_i = s.ten; ctrl_en_i = s.cen;
            busy_i = {3'b111, s.b0}; wake_i = {3'b000, s.w0}; gate_ack_i = {s.ack_hi, s.a0};
            exp_q.push_back('{n, {3'b000, s.r0}, {3'b111, s.e0}, {3'b111, s.y0}});
            @(posedge clk_i); #1; n++;
            e = exp_q.pop_front();
            checks++;
            if ({gate_req_o, clk_en_o, ready_o} !== {e.req, e.en, e.rdy}) begin
                errors++;
                $display("FAIL reset_mid step %0d: req=%h en=%h rdy=%h, expected req=%h en=%h rdy=%h",
                         e.n, gate_req_o, clk_en_o, ready_o, e.req, e.en, e.rdy);
            end
        end
    endtask

    task automatic test_ctrl_en();
        for (int i = 0; i < 20; i++) add(0, 0, 0, 0, 0, 0, 0, 1, 1);
        for (int i = 1; i <= 16; i++) add(0, 0, 1, 0, 0, 0, (i == 16), 1, 1);
        add(0, 0, 0, 0, 0, 1, 0, 1, 1);
        for (int i = 1; i <= 16; i++) add(0, 0, 1, 0, 0, 0, (i == 16), 1, 1);
        add(0, 0, 1, 0, 0, 1, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 1, 0);
        add(0, 0, 1, 1, 0, 0, 0, 1, 0);
        add(0, 0, 1, 1, 0, 0, 0, 1, 1);
        while (stim.size() > 0) begin
            s = stim.pop_front();
            rst_i = s.rst; test_en_i = s.ten; ctrl_en_i = s.cen;
            busy_i = {3'b111, s.b0}; wake_i = {3'b000, s.w0}; gate_ack_i = {s.ack_hi, s.a0};
            exp_q.push_back('{n, {3'b000, s.r0}, {3'b111, s.e0}, {3'b111, s.y0}});
            @(posedge clk_i); #1; n++;
            e = exp_q.pop_front();
            checks++;
            if ({gate_req_o, clk_en_o, ready_o} !== {e.req, e.en, e.rdy}) begin
                errors++;
                $display("FAIL ctrl_en step %0d: req=%h en=%h rdy=%h, expected req=%h en=%h rdy=%h",
                         e.n, gate_req_o, clk_en_o, ready_o, e.req, e.en, e.rdy);
            end
        end
    endtask

    initial begin
        rst_i      = 1'b1;
        test_en_i  = 1'b0;
        ctrl_en_i  = 1'b1;
        busy_i     = 4'hF;
        wake_i     = 4'h0;
        gate_ack_i = 4'h0;
        test_reset();
        test_idle_gate();
        test_wake();
        test_busy_pulse();
        test_abort();
        test_test_en();
        test_reset_mid();
        test_ctrl_en();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
